pio_regs: RTL and testbench
===========================

// Module: pio_regs
// PURPOSE
// - PIO target of sap1. Sits directly downstream of the host block and consumes
//   its PIO command stream (addr/data_w/rw/cmd_vld). Returns read responses (rd_vld/data_r).
// - Holds the ID, scratch, control and status registers plus a down-counting timer with
//   an interrupt output.
// PARAMETERS
// ID_VALUE   32'h5A01_0001  value returned by the read-only ID register
// TIMER_W    32             timer width in bits, 1..32; narrower reads zero-extend
// BAD_DATA   32'hDEAD_BEEF  read data returned for unmapped addresses
// PORTS
// clk          in   1        clock; all logic on posedge
// reset        in   1        synchronous, active-low reset (0 = reset)
// pio_addr     in   16       byte address; [1:0] ignored, decode on [15:2]
// pio_data_w   in   32       write data
// pio_rw       in   1        1 = read, 0 = write
// pio_cmd_vld  in   1        command valid; each high cycle is one command
// pio_rd_vld   out  1        read response valid (1-cycle pulse)
// pio_data_r   out  32       read data; holds last value between reads
// irq          out  1        CTRL.irq_en & STATUS.expired (combinational from flops)
// BEHAVIOUR
// - Register map:
//     0x00 ID     RO   = ID_VALUE
//     0x04 SCRATCH RW
//     0x08 CTRL   RW   [0]=timer_en, [1]=auto_reload, [2]=irq_en; [31:3] read 0
//     0x0C STATUS W1C  [0]=expired, [1]=bad_addr; [31:2] read 0
//     0x10 LOAD   RW   TIMER_W bits
//     0x14 COUNT  RO
// - Addresses 0x18..0xFFFF are unmapped. Reads return BAD_DATA; writes are dropped.
//   Any unmapped access sets STATUS.bad_addr.
// - Reset (reset==0 at posedge):
//     pio_rd_vld=0, pio_data_r=0, SCRATCH=0, CTRL=0, STATUS=0, LOAD=0, COUNT=0.
//   irq=0 follows. A command in flight is discarded; no response after reset.
// - Always ready; no backpressure; at most one command per cycle.
// - Read: cmd at edge N -> pio_rd_vld=1 and pio_data_r valid after edge N+1.
//   pio_rd_vld is 0 next cycle unless another read is issued.
//   Back-to-back reads give back-to-back responses.
// - Reads return register values before any same-edge update (pre-update snapshot).
// - Write: takes effect at the edge it is sampled. No response.
// - Timer, per edge, when timer_en=1 and COUNT!=0:
//     COUNT>1:  COUNT <= COUNT-1
//     COUNT==1: COUNT <= auto_reload ? LOAD : 0; STATUS.expired <= 1
//   COUNT==0 with auto_reload=0: timer idles, no new expiry.
//   timer_en=0: COUNT frozen.
// - Write to LOAD also loads COUNT at the same edge; the write wins over decrement.
// - LOAD=0 with auto_reload: reload to 0 stops the timer after one expiry.
// - STATUS W1C: written 1 bits clear. A same-edge hardware set (expiry or bad_addr)
//   wins over the clear.
// - Write data wider than a field is truncated to TIMER_W / field width.
// TESTING
// 1 Reset, then read 0x00, 0x0C -> rd_vld one cycle after each cmd;
//   data 0x5A010001, 0x0; irq=0.
// 2 Write SCRATCH 0xCAFEF00D, read 0x04 next cycle -> 0xCAFEF00D.
//   Back-to-back reads -> two consecutive rd_vld.
// 3 LOAD=3, CTRL=0x5 -> COUNT 3,2,1,0 on successive edges; expired=1, irq=1 at COUNT->0;
//   COUNT stays 0.
// 4 LOAD=2, CTRL=0x7 -> expiry every 2 cycles. W1C STATUS=0x1 on an expiry edge
//   -> expired stays 1.
// 5 Read 0x20 -> data 0xDEADBEEF, STATUS=0x2. Write 0x2 to 0x0C -> STATUS=0.
// 6 Issue read, assert reset next cycle -> no rd_vld, data_r=0. All registers reset.

Source files
------------

// File: rtl/pio_regs_if.sv
// PIO command/response bus between the host block and the pio_regs target.
// The master drives commands and the slave returns read responses.
interface pio_regs_if;
  logic [15:0] pio_addr;
  logic [31:0] pio_data_w;
  logic        pio_rw;
  logic        pio_cmd_vld;
  logic        pio_rd_vld;
  logic [31:0] pio_data_r;

  modport master (
    output pio_addr,
    output pio_data_w,
    output pio_rw,
    output pio_cmd_vld,
    input  pio_rd_vld,
    input  pio_data_r
  );

  modport slave (
    input  pio_addr,
    input  pio_data_w,
    input  pio_rw,
    input  pio_cmd_vld,
    output pio_rd_vld,
    output pio_data_r
  );
endinterface

// File: rtl/pio_regs.sv
// PIO register target: ID, scratch, control, status (W1C), and a down-counting
// timer with reload and an interrupt. Reads answer one cycle after the command
// and always see register values from before that edge's updates.
module pio_regs #(
  parameter logic [31:0] ID_VALUE = 32'h5A01_0001,
  parameter int          TIMER_W  = 32,
  parameter logic [31:0] BAD_DATA = 32'hDEAD_BEEF
) (
  input  logic       clk,
  input  logic       reset,
  pio_regs_if.slave  pio,
  output logic       irq
);

  // Word-aligned register offsets; the two low address bits are masked off.
  localparam logic [15:0] A_ID      = 16'h0000;
  localparam logic [15:0] A_SCRATCH = 16'h0004;
  localparam logic [15:0] A_CTRL    = 16'h0008;
  localparam logic [15:0] A_STATUS  = 16'h000C;
  localparam logic [15:0] A_LOAD    = 16'h0010;
  localparam logic [15:0] A_COUNT   = 16'h0014;
  localparam logic [15:0] A_END     = 16'h0018;

  logic [31:0]        scratch_reg;
  logic [2:0]         ctrl_reg;     // [0]=timer_en [1]=auto_reload [2]=irq_en
  logic [1:0]         status_reg;   // [0]=expired  [1]=bad_addr
  logic [TIMER_W-1:0] load_reg;
  logic [TIMER_W-1:0] count_reg;
  logic               rd_vld_reg;
  logic [31:0]        data_r_reg;

  logic [15:0]        addr_aligned;
  logic               rd_en;
  logic               wr_en;
  logic               unmapped;
  logic [31:0]        rd_data;
  logic [TIMER_W-1:0] count_next;
  logic               exp_set;
  logic [1:0]         status_set;
  logic [1:0]         status_clr;
  logic [1:0]         status_next;

  assign addr_aligned = pio.pio_addr & 16'hFFFC;
  assign rd_en        = pio.pio_cmd_vld & pio.pio_rw;
  assign wr_en        = pio.pio_cmd_vld & ~pio.pio_rw;
  assign unmapped     = addr_aligned >= A_END;

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_data = '0;
    case (addr_aligned)
      A_ID:      rd_data = ID_VALUE;
      A_SCRATCH: rd_data = scratch_reg;
      A_CTRL:    rd_data[2:0] = ctrl_reg;
      A_STATUS:  rd_data[1:0] = status_reg;
      A_LOAD:    rd_data[TIMER_W-1:0] = load_reg;
      A_COUNT:   rd_data[TIMER_W-1:0] = count_reg;
      default:   rd_data = BAD_DATA;
    endcase
  end

  // Timer next state: a LOAD write overrides the countdown for that edge.
  always_comb begin
    count_next = count_reg;
    exp_set    = 1'b0;
    if (wr_en && addr_aligned == A_LOAD) begin
      count_next = pio.pio_data_w[TIMER_W-1:0];
    end else if (ctrl_reg[0] && count_reg != '0) begin
      if (count_reg == TIMER_W'(1)) begin
        count_next = ctrl_reg[1] ? load_reg : '0;
        exp_set    = 1'b1;
      end else begin
        count_next = count_reg - TIMER_W'(1);
      end
    end
  end

  // Status bits: hardware set wins over a same-edge write-one-to-clear.
  assign status_set = {pio.pio_cmd_vld & unmapped, exp_set};
  assign status_clr = (wr_en && addr_aligned == A_STATUS) ? pio.pio_data_w[1:0] : 2'b00;

  for (genvar gi = 0; gi < 2; gi++) begin : g_status
    assign status_next[gi] = status_set[gi] | (status_reg[gi] & ~status_clr[gi]);
  end

  // Register file, timer and read response pipeline.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scratch_reg <= '0;
      ctrl_reg    <= '0;
      status_reg  <= '0;
      load_reg    <= '0;
      count_reg   <= '0;
      rd_vld_reg  <= 1'b0;
      data_r_reg  <= '0;
    end else begin
      rd_vld_reg <= rd_en;
      if (rd_en) begin
        data_r_reg <= rd_data;
      end
      if (wr_en && addr_aligned == A_SCRATCH) begin
        scratch_reg <= pio.pio_data_w;
      end
      if (wr_en && addr_aligned == A_CTRL) begin
        ctrl_reg <= pio.pio_data_w[2:0];
      end
      if (wr_en && addr_aligned == A_LOAD) begin
        load_reg <= pio.pio_data_w[TIMER_W-1:0];
      end
      count_reg  <= count_next;
      status_reg <= status_next;
    end
  end

  assign pio.pio_rd_vld = rd_vld_reg;
  assign pio.pio_data_r = data_r_reg;
  assign irq            = ctrl_reg[2] & status_reg[0];

endmodule

// File: tb/tb_pio_regs.sv
// Bench for pio_regs: expected read responses are queued when a read is issued
// and compared (data and arrival cycle) when pio_rd_vld shows up.
module tb_pio_regs;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];

  pio_regs_if bus();

  pio_regs dut (
    .clk   (clk),
    .reset (reset),
    .pio   (bus),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one command for one cycle; returns just after the capturing edge.
  task automatic cmd(input logic rw, input logic [15:0] a, input logic [31:0] d);
    bus.pio_cmd_vld = 1'b1;
    bus.pio_rw      = rw;
    bus.pio_addr    = a;
    bus.pio_data_w  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    $display("wr  addr=%h data=%h", a, d);
    cmd(1'b0, a, d);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    exp_t e;
    e.data = exp;
    e.due  = cyc + 1;
    e.tag  = tag;
    sb.push_back(e);
    cmd(1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    bus.pio_cmd_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Response monitor: pop the scoreboard on every rd_vld.
  always @(negedge clk) begin
    if (bus.pio_rd_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_vld", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rd  %s data=%h cyc=%0d", e.tag, bus.pio_data_r, cyc);
        check({e.tag, "_data"}, bus.pio_data_r, e.data);
        check({e.tag, "_cycle"}, cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pio_cmd_vld = 1'b0;
    bus.pio_rw      = 1'b0;
    bus.pio_addr    = '0;
    bus.pio_data_w  = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_vld", {31'b0, bus.pio_rd_vld}, 32'd0);
    check("reset_data_r", bus.pio_data_r, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    reset = 1'b1;
    idle(1);

    // 1: ID and STATUS after reset
    rd("id", 16'h0000, 32'h5A01_0001);
    idle(1);
    rd("status_rst", 16'h000C, 32'h0);
    idle(1);
    check("irq_idle", {31'b0, irq}, 32'd0);

    // 2: scratch write/read, back-to-back reads, low address bits ignored
    wr(16'h0004, 32'hCAFE_F00D);
    rd("scratch", 16'h0004, 32'hCAFE_F00D);
    rd("scratch_b2b", 16'h0007, 32'hCAFE_F00D);
    rd("id_b2b", 16'h0000, 32'h5A01_0001);
    idle(2);

    // 3: one-shot countdown 3,2,1,0 then expiry and irq
    wr(16'h0010, 32'd3);
    wr(16'h0008, 32'h5);
    rd("cnt3", 16'h0014, 32'd3);
    rd("cnt2", 16'h0014, 32'd2);
    check("irq_before_expiry", {31'b0, irq}, 32'd0);
    rd("cnt1", 16'h0014, 32'd1);
    check("irq_at_expiry", {31'b0, irq}, 32'd1);
    rd("cnt0", 16'h0014, 32'd0);
    rd("cnt_stays0", 16'h0014, 32'd0);
    rd("status_exp", 16'h000C, 32'h1);
    wr(16'h0008, 32'h0);
    wr(16'h000C, 32'h1);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    rd("status_clr", 16'h000C, 32'h0);
    idle(2);

    // 4: auto-reload period 2; W1C on an expiry edge loses to the set
    wr(16'h0010, 32'd2);
    wr(16'h0008, 32'h7);
    rd("ar_cnt2", 16'h0014, 32'd2);
    rd("ar_cnt1", 16'h0014, 32'd1);
    wr(16'h000C, 32'h1);
    check("ar_irq_cleared", {31'b0, irq}, 32'd0);
    rd("ar_status_clr", 16'h000C, 32'h0);
    check("ar_irq_reexpire", {31'b0, irq}, 32'd1);
    rd("ar_cnt2b", 16'h0014, 32'd2);
    wr(16'h000C, 32'h1);
    rd("ar_status_held", 16'h000C, 32'h1);
    wr(16'h0008, 32'h0);
    wr(16'h000C, 32'h1);
    rd("ar_status_final", 16'h000C, 32'h0);
    rd("ar_cnt_frozen", 16'h0014, 32'd2);
    idle(2);

    // 5: unmapped access, bad_addr, field truncation
    rd("bad_rd", 16'h0020, 32'hDEAD_BEEF);
    rd("status_bad", 16'h000C, 32'h2);
    wr(16'h000C, 32'h2);
    rd("status_bad_clr", 16'h000C, 32'h0);
    wr(16'hFFFC, 32'h1234_5678);
    rd("scratch_kept", 16'h0004, 32'hCAFE_F00D);
    rd("status_bad_wr", 16'h000C, 32'h2);
    wr(16'h000C, 32'h3);
    wr(16'h0008, 32'hFFFF_FFF8);
    rd("ctrl_trunc", 16'h0008, 32'h0);
    wr(16'h0000, 32'h0);
    rd("id_ro", 16'h0000, 32'h5A01_0001);
    idle(2);

    // 6: reset with a read in flight discards the response
    wr(16'h0010, 32'd9);
    wr(16'h0008, 32'h5);
    rd("load_pre_rst", 16'h0010, 32'd9);
    idle(1);
    bus.pio_cmd_vld = 1'b1;
    bus.pio_rw      = 1'b1;
    bus.pio_addr    = 16'h0000;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_inflight_rd_vld", {31'b0, bus.pio_rd_vld}, 32'd0);
    check("rst_inflight_data_r", bus.pio_data_r, 32'h0);
    bus.pio_cmd_vld = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    rd("rst_scratch", 16'h0004, 32'h0);
    rd("rst_ctrl", 16'h0008, 32'h0);
    rd("rst_status", 16'h000C, 32'h0);
    rd("rst_load", 16'h0010, 32'h0);
    rd("rst_count", 16'h0014, 32'h0);
    idle(3);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
